ctle_pfe_prog: RTL and testbench

- Programmable successor to the fixed two-pole/one-zero partial-fraction CTLE.
- The zero frequency, DC gain and a bypass mode are selected by codes. Codes are loaded over a valid/ready handshake and applied synchronously to clk.
- A control FSM makes every coefficient change take effect on a clock edge. After each change, ready is held low for a settle window.
- The block sits between the channel model and the slicer in link testbenches, and is the target for a future adaptation loop.

---
 rtl/ctle_prog_pkg.sv | 85 ++++++++
 rtl/ctle_prog_ctrl.sv | 106 ++++++++++
 rtl/ctle_prog_term.sv | 28 ++
 rtl/ctle_pfe_prog.sv | 80 ++++++++
 tb/tb_ctle_pfe_prog.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ctle_prog_pkg.sv
// Shared types, fixed-point constants and coefficient math for the programmable PFE CTLE.
// PWL samples are signed Q(DW-FRAC).FRAC. Each term is forward-Euler discretised at FS.
package ctle_prog_pkg;

   localparam int unsigned FZ_W        = 3;
   localparam int unsigned G_W         = 4;
   localparam int unsigned FZ_NCODE    = 6;
   localparam int unsigned SETTLE_CYC  = 4;
   localparam int unsigned RST_FZ_CODE = 0;
   localparam int unsigned RST_G_CODE  = 8;

   localparam int unsigned FRAC  = 16;
   localparam int unsigned DW    = 24;
   localparam int unsigned CW    = 20;
   localparam int unsigned GDC_W = 17;

   // Frequencies in kHz; zero steps by the rational ratio 5/4
   localparam longint FP1_KHZ      = 500_000;
   localparam longint FP2_KHZ      = 1_000_000;
   localparam longint FZ_MIN_KHZ   = 150_000;
   localparam longint FZ_RATIO_NUM = 5;
   localparam longint FZ_RATIO_DEN = 4;
   localparam longint FS_KHZ       = 16_000_000;
   localparam longint TWO_PI_Q     = 411_775;

   localparam int unsigned GDC_MIN_Q  = 32_768;
   localparam int unsigned GDC_STEP_Q = 1_311;

   typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SETTLE} state_e;

   typedef struct packed {
      logic        [GDC_W-1:0] gdc;
      logic signed [CW-1:0]    a1;
      logic signed [CW-1:0]    a2;
      logic signed [CW-1:0]    b1;
      logic signed [CW-1:0]    b2;
   } coef_t;

   function automatic longint fz_khz(input int unsigned code);
      longint num;
      longint den;
      num = FZ_MIN_KHZ;
      den = 1;
      for (int unsigned i = 0; i < FZ_NCODE; i++) begin
         if (i < code) begin
            num = num * FZ_RATIO_NUM;
            den = den * FZ_RATIO_DEN;
         end
      end
      return num / den;
   endfunction

   function automatic longint alpha_q(input longint fp);
      return (fp * TWO_PI_Q + FS_KHZ / 2) / FS_KHZ;
   endfunction

   // A/B ratios of the two terms sum to one, so DC gain is gdc alone
   function automatic coef_t calc_coef(input longint fz, input logic [GDC_W-1:0] gdc,
                                       input longint fp1, input longint fp2);
      coef_t  c;
      longint den;
      den   = fz * (fp2 - fp1);
      c.gdc = gdc;
      c.b1  = CW'(alpha_q(fp1));
      c.b2  = CW'(alpha_q(fp2));
      c.a1  = CW'(alpha_q(fp1) * (fz - fp1) * fp2 / den);
      c.a2  = CW'(alpha_q(fp2) * (fp2 - fz) * fp1 / den);
      return c;
   endfunction

   function automatic logic [GDC_W-1:0] gdc_q(input logic [G_W-1:0] g);
      return GDC_W'(GDC_MIN_Q) + GDC_W'(GDC_STEP_Q) * GDC_W'(g);
   endfunction

   // Unrolled per legal code so every calc_coef call folds to constants
   function automatic coef_t coef_for_code(input logic [FZ_W-1:0] code, input logic [G_W-1:0] g);
      coef_t c;
      c = calc_coef(fz_khz(0), gdc_q(g), FP1_KHZ, FP2_KHZ);
      for (int unsigned i = 1; i < FZ_NCODE; i++) begin
         if (code == FZ_W'(i)) c = calc_coef(fz_khz(i), gdc_q(g), FP1_KHZ, FP2_KHZ);
      end
      return c;
   endfunction

endpackage

// File: rtl/ctle_prog_ctrl.sv
// Configuration FSM: accepts code requests, clamps, applies coefficients and holds off during settle.
module ctle_prog_ctrl
   import ctle_prog_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cfg_valid_i,
   input  logic [FZ_W-1:0] cfg_fz_code_i,
   input  logic [G_W-1:0]  cfg_g_code_i,
   input  logic            cfg_bypass_i,
   output logic            cfg_ready_o,
   output logic            busy_o,
   output logic            cfg_err_o,
   output logic [FZ_W-1:0] cur_fz_code_o,
   output logic [G_W-1:0]  cur_g_code_o,
   output logic            bypass_o,
   output coef_t           coef_o
);

   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [FZ_W-1:0]   pend_fz_q;
   logic [G_W-1:0]    pend_g_q;
   logic              pend_byp_q;
   logic [FZ_W-1:0]   cur_fz_q;
   logic [G_W-1:0]    cur_g_q;
   logic              byp_q;
   logic              err_q;
   logic              ready_q;
   logic              busy_q;
   coef_t             coef_q;

   logic              clamp_d;
   logic [FZ_W-1:0]   fz_d;
   coef_t             coef_d;

   assign clamp_d = (32'(pend_fz_q) >= FZ_NCODE);
   assign fz_d    = clamp_d ? FZ_W'(FZ_NCODE - 1) : pend_fz_q;
   assign coef_d  = coef_for_code(fz_d, pend_g_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         pend_fz_q  <= '0;
         pend_g_q   <= '0;
         pend_byp_q <= 1'b0;
         cur_fz_q   <= FZ_W'(RST_FZ_CODE);
         cur_g_q    <= G_W'(RST_G_CODE);
         byp_q      <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         coef_q     <= coef_for_code(FZ_W'(RST_FZ_CODE), G_W'(RST_G_CODE));
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_valid_i && ready_q) begin
                  pend_fz_q  <= cfg_fz_code_i;
                  pend_g_q   <= cfg_g_code_i;
                  pend_byp_q <= cfg_bypass_i;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               cur_fz_q <= fz_d;
               cur_g_q  <= pend_g_q;
               byp_q    <= pend_byp_q;
               err_q    <= clamp_d;
               coef_q   <= coef_d;
               if (SETTLE_CYC == 0) begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready_o   = ready_q;
   assign busy_o        = busy_q;
   assign cfg_err_o     = err_q;
   assign cur_fz_code_o = cur_fz_q;
   assign cur_g_code_o  = cur_g_q;
   assign bypass_o      = byp_q;
   assign coef_o        = coef_q;

endmodule

// File: rtl/ctle_prog_term.sv
// One first-order partial-fraction term: y' = A*u - B*y, forward-Euler per clock.
module ctle_prog_term
   import ctle_prog_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic signed [CW-1:0] a_i,
   input  logic signed [CW-1:0] b_i,
   input  logic signed [DW-1:0] u_i,
   output logic signed [DW-1:0] y_o
);

   localparam int unsigned AW = CW + DW + 1;

   logic signed [DW-1:0] y_q;
   logic signed [DW-1:0] y_d;

   assign y_d = y_q + DW'((AW'(a_i) * AW'(u_i) - AW'(b_i) * AW'(y_q)) >>> FRAC);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) y_q <= '0;
      else                y_q <= y_d;
   end

   assign y_o = y_q;

endmodule

// File: rtl/ctle_pfe_prog.sv
// Programmable two-pole/one-zero PFE CTLE: gain stage, two PFE terms, adder and bypass/enable mux.
module ctle_pfe_prog
   import ctle_prog_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [FZ_W-1:0]      cfg_fz_code_i,
   input  logic [G_W-1:0]       cfg_g_code_i,
   input  logic                 cfg_bypass_i,
   input  logic signed [DW-1:0] in_i,
   output logic signed [DW-1:0] out_o,
   output logic                 busy_o,
   output logic [FZ_W-1:0]      cur_fz_code_o,
   output logic [G_W-1:0]       cur_g_code_o,
   output logic                 cfg_err_o
);

   localparam int unsigned UW = DW + GDC_W + 1;

   coef_t                coef;
   logic                 bypass;
   logic signed [DW-1:0] u_q;
   logic signed [DW-1:0] y1;
   logic signed [DW-1:0] y2;
   logic signed [DW-1:0] out_q;

   ctle_prog_ctrl u_ctrl (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cfg_valid_i   (cfg_valid_i),
      .cfg_fz_code_i (cfg_fz_code_i),
      .cfg_g_code_i  (cfg_g_code_i),
      .cfg_bypass_i  (cfg_bypass_i),
      .cfg_ready_o   (cfg_ready_o),
      .busy_o        (busy_o),
      .cfg_err_o     (cfg_err_o),
      .cur_fz_code_o (cur_fz_code_o),
      .cur_g_code_o  (cur_g_code_o),
      .bypass_o      (bypass),
      .coef_o        (coef)
   );

   // Gain stage feeds both terms and the bypass path
   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) u_q <= '0;
      else u_q <= DW'((UW'(in_i) * UW'($signed({1'b0, coef.gdc}))) >>> FRAC);
   end

   ctle_prog_term u_term1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (!en_i),
      .a_i   (coef.a1),
      .b_i   (coef.b1),
      .u_i   (u_q),
      .y_o   (y1)
   );

   ctle_prog_term u_term2 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (!en_i),
      .a_i   (coef.a2),
      .b_i   (coef.b2),
      .u_i   (u_q),
      .y_o   (y2)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) out_q <= '0;
      else if (bypass)    out_q <= u_q;
      else                out_q <= y1 + y2;
   end

   assign out_o = out_q;

endmodule

// File: tb/tb_ctle_pfe_prog.sv
// Directed bench for ctle_pfe_prog: handshake timing, clamping, reset abort, bypass, enable and DC levels.
module tb_ctle_pfe_prog;
   import ctle_prog_pkg::*;

   localparam int HALF    = 32768;
   localparam int EXP_033 = 21627;
   localparam int EXP_025 = 16384;
   localparam int EXP_040 = 26214;
   localparam int ETOL_Q  = 66;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b0;
   logic                 cfg_valid = 1'b0;
   logic                 cfg_ready;
   logic [FZ_W-1:0]      cfg_fz_code = '0;
   logic [G_W-1:0]       cfg_g_code = '0;
   logic                 cfg_bypass = 1'b0;
   logic signed [DW-1:0] in_s = '0;
   logic signed [DW-1:0] out_s;
   logic                 busy;
   logic [FZ_W-1:0]      cur_fz_code;
   logic [G_W-1:0]       cur_g_code;
   logic                 cfg_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ctle_pfe_prog dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en),
      .cfg_valid_i   (cfg_valid),
      .cfg_ready_o   (cfg_ready),
      .cfg_fz_code_i (cfg_fz_code),
      .cfg_g_code_i  (cfg_g_code),
      .cfg_bypass_i  (cfg_bypass),
      .in_i          (in_s),
      .out_o         (out_s),
      .busy_o        (busy),
      .cur_fz_code_o (cur_fz_code),
      .cur_g_code_o  (cur_g_code),
      .cfg_err_o     (cfg_err)
   );

   function automatic int absd(input int a);
      return (a < 0) ? -a : a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request so it is accepted on the next edge; returns just after that edge
   task automatic issue(input int fz, input int g, input logic byp);
      cfg_valid   = 1'b1;
      cfg_fz_code = FZ_W'(fz);
      cfg_g_code  = G_W'(g);
      cfg_bypass  = byp;
      tick();
      cfg_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; in_s = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", cfg_err); end
      n_checks++; if (cur_fz_code !== 3'd0) begin n_fail++; $display("FAIL reset_fz got %0d want 0", cur_fz_code); end
      n_checks++; if (cur_g_code !== 4'd8) begin n_fail++; $display("FAIL reset_g got %0d want 8", cur_g_code); end
      n_checks++; if (out_s !== '0) begin n_fail++; $display("FAIL reset_out got %0d want 0", out_s); end
   endtask

   task automatic test_dc_step();
      int peak;
      peak = -(1 << 30);
      in_s = DW'(HALF);
      repeat (150) begin
         tick();
         if (int'(out_s) > peak) peak = int'(out_s);
      end
      n_checks++; if (absd(int'(out_s) - EXP_033) > ETOL_Q) begin n_fail++; $display("FAIL dc_step_033 got %0d want %0d", out_s, EXP_033); end
      n_checks++; if (peak <= EXP_033 + 3277) begin n_fail++; $display("FAIL dc_step_peaking got peak %0d want > %0d", peak, EXP_033 + 3277); end
   endtask

   task automatic test_request();
      issue(3, 0, 1'b0);
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL req_ready_n got %b want 0", cfg_ready); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL req_busy_n got %b want 1", busy); end
      n_checks++; if (cur_fz_code !== 3'd0) begin n_fail++; $display("FAIL req_fz_n got %0d want 0", cur_fz_code); end
      tick();
      n_checks++; if (cur_fz_code !== 3'd3) begin n_fail++; $display("FAIL req_fz_n1 got %0d want 3", cur_fz_code); end
      n_checks++; if (cur_g_code !== 4'd0) begin n_fail++; $display("FAIL req_g_n1 got %0d want 0", cur_g_code); end
      tick(); tick(); tick();
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL req_ready_n4 got %b want 0", cfg_ready); end
      tick();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL req_ready_n5 got %b want 1", cfg_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_busy_n5 got %b want 0", busy); end
      in_s = '0;
      repeat (150) tick();
      n_checks++; if (absd(int'(out_s)) > ETOL_Q) begin n_fail++; $display("FAIL req_zero got %0d want 0", out_s); end
      in_s = DW'(HALF);
      repeat (150) tick();
      n_checks++; if (absd(int'(out_s) - EXP_025) > ETOL_Q) begin n_fail++; $display("FAIL req_dc_025 got %0d want %0d", out_s, EXP_025); end
   endtask

   task automatic test_clamp();
      issue(7, 8, 1'b0);
      repeat (5) tick();
      n_checks++; if (cur_fz_code !== 3'd5) begin n_fail++; $display("FAIL clamp_fz got %0d want 5", cur_fz_code); end
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL clamp_err got %b want 1", cfg_err); end
      issue(2, 8, 1'b0);
      repeat (5) tick();
      n_checks++; if (cur_fz_code !== 3'd2) begin n_fail++; $display("FAIL legal_fz got %0d want 2", cur_fz_code); end
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL legal_err got %b want 0", cfg_err); end
   endtask

   task automatic test_back_to_back();
      cfg_valid = 1'b1;
      cfg_bypass = 1'b0;
      for (int i = 0; i < 24; i++) begin
         cfg_fz_code = FZ_W'(i % 5);
         cfg_g_code  = G_W'((i * 3) % 16);
         tick();
         n_checks++;
         if (cfg_ready !== ((i % 6) == 5)) begin
            n_fail++; $display("FAIL b2b_ready[%0d] got %b want %b", i, cfg_ready, (i % 6) == 5);
         end
         if ((i % 6) == 1) begin
            n_checks++;
            if (cur_fz_code !== FZ_W'((i - 1) % 5)) begin
               n_fail++; $display("FAIL b2b_fz[%0d] got %0d want %0d", i, cur_fz_code, (i - 1) % 5);
            end
            n_checks++;
            if (cur_g_code !== G_W'(((i - 1) * 3) % 16)) begin
               n_fail++; $display("FAIL b2b_g[%0d] got %0d want %0d", i, cur_g_code, ((i - 1) * 3) % 16);
            end
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_rst_settle();
      issue(7, 3, 1'b0);
      tick();
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rs_err_pre got %b want 1", cfg_err); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rs_ready got %b want 1", cfg_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy got %b want 0", busy); end
      n_checks++; if (cur_fz_code !== 3'd0) begin n_fail++; $display("FAIL rs_fz got %0d want 0", cur_fz_code); end
      n_checks++; if (cur_g_code !== 4'd8) begin n_fail++; $display("FAIL rs_g got %0d want 8", cur_g_code); end
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rs_err got %b want 0", cfg_err); end
      rst = 1'b1; cfg_valid = 1'b1; cfg_fz_code = 3'd4; cfg_g_code = 4'd1;
      tick();
      rst = 1'b0; cfg_valid = 1'b0;
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rv_ready got %b want 1", cfg_ready); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rv_busy got %b want 0", busy); end
      n_checks++; if (cur_fz_code !== 3'd0) begin n_fail++; $display("FAIL rv_fz got %0d want 0", cur_fz_code); end
   endtask

   task automatic test_bypass_en();
      int peak;
      issue(0, 15, 1'b1);
      repeat (5) tick();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready got %b want 1", cfg_ready); end
      in_s = '0;
      repeat (20) tick();
      peak = -(1 << 30);
      in_s = DW'(HALF);
      repeat (40) begin
         tick();
         if (int'(out_s) > peak) peak = int'(out_s);
      end
      n_checks++; if (absd(int'(out_s) - EXP_040) > ETOL_Q) begin n_fail++; $display("FAIL byp_dc got %0d want %0d", out_s, EXP_040); end
      n_checks++; if (peak > int'(out_s)) begin n_fail++; $display("FAIL byp_overshoot got peak %0d want <= %0d", peak, out_s); end
      en = 1'b0;
      tick(); tick();
      n_checks++; if (out_s !== '0) begin n_fail++; $display("FAIL en0_out got %0d want 0", out_s); end
      issue(0, 8, 1'b0);
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL en0_ready_n got %b want 0", cfg_ready); end
      repeat (5) tick();
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL en0_ready_n5 got %b want 1", cfg_ready); end
      n_checks++; if (out_s !== '0) begin n_fail++; $display("FAIL en0_out_late got %0d want 0", out_s); end
      en = 1'b1;
      repeat (150) tick();
      n_checks++; if (absd(int'(out_s) - EXP_033) > ETOL_Q) begin n_fail++; $display("FAIL en1_dc got %0d want %0d", out_s, EXP_033); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_dc_step();
      test_request();
      test_clamp();
      test_back_to_back();
      test_rst_settle();
      test_bypass_en();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
